// File: rtl/o_serdes_gearbox.sv
// o_serdes_gearbox: parallel-to-serial gearbox for NUM_CH bonded lanes that
// share one valid/ready handshake. Each lane owns a shift register. A single
// one-word holding register lets the next word wait while the current word is
// still shifting out, so back-to-back words stream with no idle beats.
// SDR emits one bit per lane per clock. DDR emits two bits per lane per clock.
// Optional feature: define O_SERDES_GEARBOX_BITSLIP_EN to add the BITSLIP
// input. Each BITSLIP pulse rotates every newly loaded word right by one more
// bit per lane.
module o_serdes_gearbox #(
  parameter int   WIDTH      = 4,
  parameter int   NUM_CH     = 1,
  parameter       DATA_RATE  = "SDR",
  parameter logic IDLE_VALUE = 1'b0,
  localparam int  R          = (DATA_RATE == "DDR") ? 2 : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [NUM_CH*WIDTH-1:0] D,
  input  logic                    D_VALID,
  output logic                    D_READY,
  output logic [NUM_CH*R-1:0]     Q,
  output logic                    WORD_START,
  output logic                    UNDERRUN
`ifdef O_SERDES_GEARBOX_BITSLIP_EN
  ,
  input  logic                    BITSLIP
`endif
);

  localparam int DW    = NUM_CH * WIDTH;
  localparam int QW    = NUM_CH * R;
  localparam int BEATS = WIDTH / R;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // Reject illegal configurations at elaboration time.
  if (DATA_RATE != "SDR" && DATA_RATE != "DDR") begin : g_bad_rate
    $error("o_serdes_gearbox: DATA_RATE must be \"SDR\" or \"DDR\"");
  end
  if (DATA_RATE == "DDR" && (WIDTH % 2) != 0) begin : g_bad_ddr_width
    $error("o_serdes_gearbox: DDR requires an even WIDTH");
  end
  if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
    $error("o_serdes_gearbox: WIDTH must be 3..10");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("o_serdes_gearbox: NUM_CH must be 1..8");
  end

  typedef enum logic [1:0] {IDLE, RUN, STARVED} state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic [DW-1:0]   shifter;
  logic [DW-1:0]   hold;
  logic            hold_full;

  logic            accept;
  logic            final_beat;
  logic            load_d;
  logic            load_hold;
  logic            hold_wr;
  logic [QW-1:0]   q_beat;
  logic [DW-1:0]   shifted;
  logic [DW-1:0]   d_load;
  logic [DW-1:0]   hold_load;

`ifdef O_SERDES_GEARBOX_BITSLIP_EN
  localparam int RW = $clog2(WIDTH);
  logic [RW-1:0] rot;

  // Rotate one lane word right by n bits. Bit n of the input becomes bit 0.
  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] w,
                                                 input logic [RW-1:0]    n);
    logic [2*WIDTH-1:0] dbl;
    dbl = {w, w} >> n;
    return dbl[WIDTH-1:0];
  endfunction

  // Rotation counter: each BITSLIP sample taken while enabled advances it by one, modulo WIDTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rot <= '0;
    end else if (EN && BITSLIP) begin
      rot <= (rot == RW'(WIDTH - 1)) ? '0 : rot + 1'b1;
    end
  end
`endif

  // A word is taken only when the holding slot is free, the block is enabled and it is not in reset.
  assign D_READY    = EN & ~RST & ~hold_full;
  assign accept     = D_VALID & D_READY;
  assign final_beat = (state == RUN) && (beat_cnt == LAST_BEAT);
  // The held word always wins the final-beat slot; D_READY is low whenever it is present.
  assign load_hold  = final_beat & hold_full;
  assign load_d     = accept & ((state != RUN) | final_beat);
  assign hold_wr    = accept & ~load_d;

  // Per-lane slicing: the current beat, the shifted remainder and the word that would load next.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so that no path can leave a value unassigned (latch).
    q_beat    = '0;
    shifted   = '0;
    d_load    = '0;
    hold_load = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      q_beat[c*R +: R]          = shifter[c*WIDTH +: R];
      shifted[c*WIDTH +: WIDTH] = shifter[c*WIDTH +: WIDTH] >> R;
`ifdef O_SERDES_GEARBOX_BITSLIP_EN
      d_load[c*WIDTH +: WIDTH]    = rot_right(D[c*WIDTH +: WIDTH], rot);
      hold_load[c*WIDTH +: WIDTH] = rot_right(hold[c*WIDTH +: WIDTH], rot);
`else
      d_load[c*WIDTH +: WIDTH]    = D[c*WIDTH +: WIDTH];
      hold_load[c*WIDTH +: WIDTH] = hold[c*WIDTH +: WIDTH];
`endif
    end
  end

  // Datapath registers: the shifter and the holding word.
  always_ff @(posedge CLK) begin
    // NOTE: these data registers are intentionally not reset. Their contents
    // mean nothing unless state/hold_full say so, and those flags are reset.
    if (EN) begin
      if (load_d) begin
        shifter <= d_load;
      end else if (load_hold) begin
        shifter <= hold_load;
      end else if (state == RUN) begin
        shifter <= shifted;
      end
      if (hold_wr) begin
        hold <= D;
      end
    end
  end

  // Control FSM plus the registered outputs Q, WORD_START and UNDERRUN.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking '<=' so that every register
    // samples values from before the clock edge.
    if (RST) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      hold_full  <= 1'b0;
      Q          <= {QW{IDLE_VALUE}};
      WORD_START <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else if (EN) begin
      if (hold_wr) begin
        hold_full <= 1'b1;
      end else if (load_hold) begin
        hold_full <= 1'b0;
      end

      case (state)
        RUN: begin
          Q          <= q_beat;
          WORD_START <= (beat_cnt == '0);
          UNDERRUN   <= 1'b0;
          if (final_beat) begin
            beat_cnt <= '0;
            if (!load_hold && !load_d) begin
              state <= STARVED;
            end
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          Q          <= {QW{IDLE_VALUE}};
          WORD_START <= 1'b0;
          UNDERRUN   <= (state == STARVED);
          if (load_d) begin
            state    <= RUN;
            beat_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_o_serdes_gearbox.sv
// Testbench for o_serdes_gearbox. It drives three configurations:
//   A: WIDTH=4, SDR, 1 lane,  IDLE_VALUE=0 (vector table, streaming, bitslip)
//   B: WIDTH=8, DDR, 2 lanes, IDLE_VALUE=1 (beat-queue reference model)
//   C: WIDTH=8, SDR, 1 lane,  IDLE_VALUE=1 (reset mid-word, EN freeze)
module tb_o_serdes_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A ----------------
  logic       a_rst, a_en, a_dv, a_ready, a_ws, a_ur;
  logic [3:0] a_d;
  logic [0:0] a_q;
`ifdef O_SERDES_GEARBOX_BITSLIP_EN
  logic       a_bitslip;
`endif

  o_serdes_gearbox #(.WIDTH(4), .NUM_CH(1), .DATA_RATE("SDR"), .IDLE_VALUE(1'b0)) dut_a (
    .CLK(clk), .RST(a_rst), .EN(a_en), .D(a_d), .D_VALID(a_dv), .D_READY(a_ready),
    .Q(a_q), .WORD_START(a_ws), .UNDERRUN(a_ur)
`ifdef O_SERDES_GEARBOX_BITSLIP_EN
    , .BITSLIP(a_bitslip)
`endif
  );

  // ---------------- DUT B ----------------
  logic        b_rst, b_en, b_dv, b_ready, b_ws, b_ur;
  logic [15:0] b_d;
  logic [3:0]  b_q;

  o_serdes_gearbox #(.WIDTH(8), .NUM_CH(2), .DATA_RATE("DDR"), .IDLE_VALUE(1'b1)) dut_b (
    .CLK(clk), .RST(b_rst), .EN(b_en), .D(b_d), .D_VALID(b_dv), .D_READY(b_ready),
    .Q(b_q), .WORD_START(b_ws), .UNDERRUN(b_ur)
`ifdef O_SERDES_GEARBOX_BITSLIP_EN
    , .BITSLIP(1'b0)
`endif
  );

  // ---------------- DUT C ----------------
  logic       c_rst, c_en, c_dv, c_ready, c_ws, c_ur;
  logic [7:0] c_d;
  logic [0:0] c_q;

  o_serdes_gearbox #(.WIDTH(8), .NUM_CH(1), .DATA_RATE("SDR"), .IDLE_VALUE(1'b1)) dut_c (
    .CLK(clk), .RST(c_rst), .EN(c_en), .D(c_d), .D_VALID(c_dv), .D_READY(c_ready),
    .Q(c_q), .WORD_START(c_ws), .UNDERRUN(c_ur)
`ifdef O_SERDES_GEARBOX_BITSLIP_EN
    , .BITSLIP(1'b0)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table for DUT A ----------------
  typedef struct {
    logic       rst, en, dv;
    logic [3:0] d;
    logic       exp_ready, exp_q, exp_ws, exp_ur;
  } vec_t;
  vec_t vq[$];

  task automatic v(input logic rst, en, dv, input logic [3:0] d,
                   input logic r, q, ws, ur);
    vec_t e;
    e.rst = rst; e.en = en; e.dv = dv; e.d = d;
    e.exp_ready = r; e.exp_q = q; e.exp_ws = ws; e.exp_ur = ur;
    vq.push_back(e);
  endtask

  task automatic a_step(input logic rst, en, dv, input logic [3:0] d);
    @(negedge clk);
    a_rst = rst; a_en = en; a_dv = dv; a_d = d;
    @(posedge clk); #1;
  endtask

  task automatic c_step(input logic rst, en, dv, input logic [7:0] d);
    @(negedge clk);
    c_rst = rst; c_en = en; c_dv = dv; c_d = d;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model for DUT B ----------------
  // Every accepted word becomes four beats, appended to a queue of pending
  // beats. Each enabled edge presents the oldest pending beat on Q, or the
  // idle value when nothing is pending. The holding slot is free while no more
  // than one word's worth of beats is outstanding.
  typedef struct {
    logic [3:0] q;
    logic       ws;
  } beat_t;
  beat_t      bq[$];
  bit         b_started = 0;
  logic [3:0] b_eq  = 4'hF;
  logic       b_ews = 1'b0;
  logic       b_eur = 1'b0;
  int         b_accepts = 0;
  int         b_ws_seen = 0;

  task automatic b_cycle(input logic rst, en, dv, input logic [15:0] d);
    logic  exp_ready;
    bit    popped;
    beat_t nb;
    @(negedge clk);
    b_rst = rst; b_en = en; b_dv = dv; b_d = d;
    #1;
    exp_ready = en && !rst && (bq.size() <= 4);
    check("b_ready", b_ready, exp_ready);
    if (rst) begin
      bq.delete();
      b_started = 0;
      b_eq = 4'hF; b_ews = 1'b0; b_eur = 1'b0;
    end else if (en) begin
      popped = (bq.size() > 0);
      if (popped) begin
        nb = bq.pop_front();
        b_eq = nb.q; b_ews = nb.ws;
      end else begin
        b_eq = 4'hF; b_ews = 1'b0;
      end
      b_eur = b_started && !popped;
      if (dv && exp_ready) begin
        for (int k = 0; k < 4; k++) begin
          for (int c = 0; c < 2; c++)
            for (int r = 0; r < 2; r++)
              nb.q[c*2 + r] = d[c*8 + k*2 + r];
          nb.ws = (k == 0);
          bq.push_back(nb);
        end
        b_started = 1;
        b_accepts++;
      end
    end
    @(posedge clk); #1;
    check("b_q", b_q, b_eq);
    check("b_ws", b_ws, b_ews);
    check("b_ur", b_ur, b_eur);
    if (b_ws) b_ws_seen++;
  endtask

  // Bookkeeping for the DUT A streaming scoreboard.
  logic [3:0] expq[$];
  int         acc, emitted, bitpos, ur_hits;
  bit         collecting;
  logic [3:0] w, ew;
  logic [7:0] got8;
  logic       last_q;

`ifdef O_SERDES_GEARBOX_BITSLIP_EN
  task automatic a_send_collect(input logic [3:0] d, output logic [3:0] got);
    int pos;
    pos = -1;
    got = '0;
    a_bitslip = 1'b0;
    a_step(0, 1, 1, d);
    for (int i = 0; i < 6; i++) begin
      a_step(0, 1, 0, 4'h0);
      if (a_ws) pos = 0;
      if (pos >= 0 && pos < 4) begin
        got[pos] = a_q[0];
        pos++;
      end
    end
  endtask

  task automatic a_pulse_bitslip();
    @(negedge clk);
    a_rst = 0; a_en = 1; a_dv = 0; a_bitslip = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a_bitslip = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] got4;
    a_rst = 1; a_en = 0; a_dv = 0; a_d = '0;
    b_rst = 1; b_en = 0; b_dv = 0; b_d = '0;
    c_rst = 1; c_en = 0; c_dv = 0; c_d = '0;
`ifdef O_SERDES_GEARBOX_BITSLIP_EN
    a_bitslip = 1'b0;
`endif

    // ---- DUT A: table of cycle vectors (rst,en,dv,d | ready,q,ws,ur) ----
    v(1, 1, 0, 4'h0,  0, 0, 0, 0);  // reset
    v(0, 1, 1, 4'hA,  1, 0, 0, 0);  // accept 1010 from IDLE
    v(0, 1, 0, 4'h0,  1, 0, 1, 0);  // bit0
    v(0, 1, 0, 4'h0,  1, 1, 0, 0);
    v(0, 1, 0, 4'h0,  1, 0, 0, 0);
    v(0, 1, 0, 4'h0,  1, 1, 0, 0);  // bit3, final beat
    v(0, 1, 0, 4'h0,  1, 0, 0, 1);  // starved
    v(0, 1, 1, 4'h6,  1, 0, 0, 1);  // accept 0110 from STARVED
    v(0, 1, 1, 4'hC,  1, 0, 1, 0);  // 1100 goes to the holding slot
    v(0, 1, 1, 4'h3,  0, 1, 0, 0);  // holding slot full: backpressure
    v(0, 1, 1, 4'h3,  0, 1, 0, 0);
    v(0, 1, 1, 4'h3,  0, 0, 0, 0);  // final beat, held word moves up
    v(0, 1, 1, 4'h3,  1, 0, 1, 0);  // 0011 accepted into holding slot
    v(0, 1, 0, 4'h0,  0, 0, 0, 0);
    v(0, 1, 0, 4'h0,  0, 1, 0, 0);
    v(0, 1, 0, 4'h0,  0, 1, 0, 0);
    v(0, 1, 0, 4'h0,  1, 1, 1, 0);  // 0011 bit0
    v(0, 0, 1, 4'hF,  0, 1, 1, 0);  // EN low: frozen
    v(0, 0, 0, 4'h0,  0, 1, 1, 0);
    v(0, 1, 0, 4'h0,  1, 1, 0, 0);  // resume at bit1
    v(0, 1, 0, 4'h0,  1, 0, 0, 0);
    v(0, 1, 0, 4'h0,  1, 0, 0, 0);
    v(0, 1, 0, 4'h0,  1, 0, 0, 1);  // starved
    v(1, 0, 1, 4'h0,  0, 0, 0, 0);  // reset with EN low
    v(0, 1, 0, 4'h0,  1, 0, 0, 0);  // back to IDLE, not starved

    foreach (vq[i]) begin
      @(negedge clk);
      a_rst = vq[i].rst; a_en = vq[i].en; a_dv = vq[i].dv; a_d = vq[i].d;
      #1;
      check($sformatf("a_ready[%0d]", i), a_ready, vq[i].exp_ready);
      @(posedge clk); #1;
      check($sformatf("a_q[%0d]", i),  a_q,  vq[i].exp_q);
      check($sformatf("a_ws[%0d]", i), a_ws, vq[i].exp_ws);
      check($sformatf("a_ur[%0d]", i), a_ur, vq[i].exp_ur);
    end

    // ---- DUT A: 100 random words with D_VALID held high ----
    a_step(1, 1, 0, 4'h0);
    acc = 0; emitted = 0; bitpos = 0; ur_hits = 0; collecting = 0; w = '0;
    for (int cyc = 0; cyc < 1000 && emitted < 100; cyc++) begin
      @(negedge clk);
      a_rst = 0; a_en = 1; a_dv = (acc < 100); a_d = 4'($urandom);
      #1;
      if (a_dv && a_ready) begin
        expq.push_back(a_d);
        acc++;
      end
      @(posedge clk); #1;
      if (a_ur) ur_hits++;
      if (a_ws) begin
        collecting = 1; bitpos = 0;
      end
      if (collecting) begin
        w[bitpos] = a_q[0];
        bitpos++;
        if (bitpos == 4) begin
          ew = (expq.size() > 0) ? expq.pop_front() : ~w;
          check("a_stream_word", w, ew);
          emitted++;
          collecting = 0;
        end
      end
    end
    check("a_stream_accepted", acc, 100);
    check("a_stream_emitted", emitted, 100);
    check("a_stream_underrun", ur_hits, 0);

    // ---- DUT C: reset at beat 2 with a word held ----
    c_step(1, 1, 0, 8'h00);
    c_step(0, 1, 1, 8'hA5);
    c_step(0, 1, 1, 8'h3C);
    check("c_bit0", c_q, 1'b1);
    check("c_bit0_ws", c_ws, 1'b1);
    c_step(0, 1, 0, 8'h00);
    check("c_bit1", c_q, 1'b0);
    @(negedge clk);
    c_rst = 1; c_en = 0; c_dv = 0;
    #1;
    check("c_ready_in_reset", c_ready, 1'b0);
    @(posedge clk); #1;
    check("c_rst_q", c_q, 1'b1);
    check("c_rst_ws", c_ws, 1'b0);
    check("c_rst_ur", c_ur, 1'b0);
    @(negedge clk);
    c_rst = 0; c_en = 1;
    #1;
    check("c_ready_after_reset", c_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      c_step(0, 1, 0, 8'h00);
      check("c_no_residual", {c_q, c_ws, c_ur}, 3'b100);
    end
    c_step(0, 1, 1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      c_step(0, 1, 0, 8'h00);
      check("c_zero_word_q", c_q, 1'b0);
      check("c_zero_word_ws", c_ws, (i == 0));
    end
    c_step(0, 1, 0, 8'h00);
    check("c_after_word_q", c_q, 1'b1);
    check("c_after_word_ur", c_ur, 1'b1);

    // ---- DUT C: EN low for 3 cycles mid-word ----
    got8 = '0;
    c_step(0, 1, 1, 8'hB2);
    for (int i = 0; i < 3; i++) begin
      c_step(0, 1, 0, 8'h00);
      got8[i] = c_q[0];
      if (i == 0) check("c_freeze_ws", c_ws, 1'b1);
    end
    last_q = c_q[0];
    for (int i = 0; i < 3; i++) begin
      c_step(0, 0, 1, 8'hFF);
      check("c_freeze_q", c_q, last_q);
      check("c_freeze_ws_hold", c_ws, 1'b0);
    end
    for (int i = 3; i < 8; i++) begin
      c_step(0, 1, 0, 8'h00);
      got8[i] = c_q[0];
    end
    check("c_freeze_word", got8, 8'hB2);

    // ---- DUT B: three words streamed back to back ----
    b_cycle(1, 1, 0, 16'h0);
    b_accepts = 0; b_ws_seen = 0;
    for (int i = 0; i < 12 && b_accepts < 3; i++) b_cycle(0, 1, 1, 16'($urandom));
    for (int i = 0; i < 16; i++) b_cycle(0, 1, 0, 16'h0);
    check("b_three_accepted", b_accepts, 3);
    check("b_three_word_starts", b_ws_seen, 3);

    // ---- DUT B: randomized traffic against the model ----
    for (int i = 0; i < 1500; i++) begin
      b_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 2) != 0), 16'($urandom));
    end

`ifdef O_SERDES_GEARBOX_BITSLIP_EN
    // ---- DUT A: bitslip rotation ----
    a_step(1, 1, 0, 4'h0);
    a_send_collect(4'b0001, got4);
    check("bitslip_none", got4, 4'b0001);
    a_pulse_bitslip();
    a_send_collect(4'b0001, got4);
    check("bitslip_one", got4, 4'b1000);
    for (int i = 0; i < 3; i++) a_pulse_bitslip();
    a_send_collect(4'b0001, got4);
    check("bitslip_wrap", got4, 4'b0001);
`else
    got4 = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
